// File: rtl/filter_pkg.sv
// Shared definitions for the 3x3 window filter front end.
// Holds the raster word layout used on the filter data input ({valid, pixel})
// and the state encoding of the frame-read sequencer.
package filter_pkg;

  localparam int PIX_W     = 8;
  localparam int WORD_W    = 9;
  localparam int VALID_BIT = 8;
  localparam int MAX_WIDTH = 1024;

  // Pixel counter width: 1024 * 65535 pixels fits in 26 bits.
  localparam int PIXCNT_W  = 26;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFILL,
    ST_STREAM,
    ST_FLUSH,
    ST_DONE
  } state_e;

  function automatic logic [WORD_W-1:0] pack_word(input logic vld,
                                                  input logic [PIX_W-1:0] pix);
    logic [WORD_W-1:0] w;
    w            = '0;
    w[VALID_BIT] = vld;
    w[PIX_W-1:0] = pix;
    return w;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Prefetch FIFO between the memory fetcher and the raster emitter.
// Synchronous, first-word-fall-through read (pop_data shows the head entry).
// Ports:
//   clk, rst (async, active-low) - clock and reset of pointers/count
//   clr                          - synchronous flush of all entries
//   push, push_data              - write one pixel (ignored when full)
//   pop, pop_data                - consume head pixel (ignored when empty)
//   count, full, empty           - occupancy status
module stream_fifo
  import filter_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [PIX_W-1:0] push_data,
  input  logic             pop,
  output logic [PIX_W-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [PIX_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/filter_stream_source.sv
// Frame-read front end for the 3x3 window filter.
// Fetches a W x H grayscale frame from pixel memory (one request outstanding
// at a time) into a prefetch FIFO and emits it as a free-running raster of
// 9-bit words {valid, pixel}, followed by W+2 padding words so the filter's
// line buffers and window drain.
// Ports:
//   clk, rst (async, active-low)
//   start                       - begin a frame (only honoured when idle)
//   image_width/height, base_addr - frame geometry, latched on start
//   mem_req/mem_addr/mem_ack/mem_rdata - pixel memory read port
//   data_out                    - {valid, pixel} raster word
//   busy, done, underrun        - frame status
module filter_stream_source
  import filter_pkg::*;
#(
  parameter int ADDR_W     = 26,
  parameter int FIFO_DEPTH = 16,
  parameter int PREFILL    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       image_width,
  input  logic [31:0]       image_height,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [WORD_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int COL_W = $clog2(MAX_WIDTH) + 1;
  localparam int ROW_W = 16;

  state_e              state_q, state_d;
  logic [COL_W-1:0]    width_q, width_d;
  logic [ROW_W-1:0]    height_q, height_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [PIXCNT_W-1:0] total_q, total_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    flush_q, flush_d;
  logic [PIXCNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                drop_q, drop_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                underrun_q, underrun_d;

  logic                fifo_push, fifo_pop, fifo_clr;
  logic [PIX_W-1:0]    fifo_rdata;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full, fifo_empty;
  logic                fetch_active;
  logic [CNT_W:0]      occupancy;

  stream_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (fifo_clr),
    .push      (fifo_push),
    .push_data (mem_rdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign fetch_active = (state_q == ST_PREFILL) || (state_q == ST_STREAM) ||
                        (state_q == ST_FLUSH);
  // FIFO slots already spoken for: stored pixels plus the request in flight.
  assign occupancy    = {1'b0, fifo_count} + {{CNT_W{1'b0}}, mem_req_q};

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    base_d      = base_q;
    total_d     = total_q;
    col_d       = col_q;
    row_d       = row_q;
    flush_d     = flush_q;
    fetch_cnt_d = fetch_cnt_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    drop_d      = drop_q;
    data_d      = '0;
    underrun_d  = underrun_q;
    done_d      = 1'b0;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    fifo_clr    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          width_d     = image_width[COL_W-1:0];
          height_d    = image_height[ROW_W-1:0];
          base_d      = base_addr;
          total_d     = PIXCNT_W'(image_width[COL_W-1:0]) *
                        PIXCNT_W'(image_height[ROW_W-1:0]);
          col_d       = '0;
          row_d       = '0;
          flush_d     = '0;
          fetch_cnt_d = '0;
          underrun_d  = 1'b0;
          fifo_clr    = 1'b1;
          // A request left over from the previous frame must not land in
          // this frame's FIFO.
          drop_d      = mem_req_q && !mem_ack;
          state_d     = ((image_width == 32'd0) || (image_height == 32'd0)) ?
                        ST_DONE : ST_PREFILL;
        end
      end

      ST_PREFILL: begin
        if ((fifo_count >= CNT_W'(PREFILL)) || (fetch_cnt_q == total_q))
          state_d = ST_STREAM;
      end

      ST_STREAM: begin
        // An empty FIFO still consumes the slot so the raster keeps its timing.
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          data_d   = pack_word(1'b1, fifo_rdata);
        end else begin
          underrun_d = 1'b1;
        end
        if (col_q == width_q - COL_W'(1)) begin
          col_d = '0;
          row_d = row_q + ROW_W'(1);
          if (row_q == height_q - ROW_W'(1)) begin
            flush_d = '0;
            state_d = ST_FLUSH;
          end
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end

      ST_FLUSH: begin
        // One row plus two columns of zeros drains the filter window.
        flush_d = flush_q + COL_W'(1);
        if ({1'b0, flush_q} == ({1'b0, width_q} + (COL_W+1)'(1)))
          state_d = ST_DONE;
      end

      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);

    // Fetcher: one request at a time; a new one is raised no earlier than the
    // cycle after the previous ack.
    if (mem_req_q) begin
      if (mem_ack) begin
        mem_req_d = 1'b0;
        if (drop_q) begin
          drop_d = 1'b0;
        end else if (fetch_active) begin
          fifo_push   = !fifo_full;
          fetch_cnt_d = fetch_cnt_q + PIXCNT_W'(1);
        end
      end
    end else if (fetch_active && (fetch_cnt_q != total_q) &&
                 (occupancy < (CNT_W+1)'(FIFO_DEPTH))) begin
      mem_req_d  = 1'b1;
      mem_addr_d = base_q + ADDR_W'(fetch_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      width_q     <= '0;
      height_q    <= '0;
      base_q      <= '0;
      total_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      flush_q     <= '0;
      fetch_cnt_q <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      drop_q      <= 1'b0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      base_q      <= base_d;
      total_q     <= total_d;
      col_q       <= col_d;
      row_q       <= row_d;
      flush_q     <= flush_d;
      fetch_cnt_q <= fetch_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      drop_q      <= drop_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign data_out = data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_filter_stream_source.sv
module tb_filter_stream_source;

  localparam int ADDR_W = 26;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       image_width = '0;
  logic [31:0]       image_height = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [7:0]        mem_rdata = '0;
  logic [8:0]        data_out;
  logic              busy, done, underrun;

  filter_stream_source #(
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (16),
    .PREFILL    (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .image_width  (image_width),
    .image_height (image_height),
    .base_addr    (base_addr),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .data_out     (data_out),
    .busy         (busy),
    .done         (done),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Memory model: pixel at base+n holds 0x10+n. Ack after mem_lat waiting
  // cycles (0 = ack in the request cycle). Tracks address continuity per frame.
  logic              resp_en = 1'b1;
  logic              late_ack = 1'b0;
  int                mem_lat = 0;
  logic [ADDR_W-1:0] mem_base = '0;
  int                frame_seq = 0;
  int                seen_seq = 0;
  int                wcnt = 0;
  logic [ADDR_W-1:0] exp_addr = '0;
  int                addr_errs = 0;
  int                n_acks = 0;
  int                req_cycles = 0;

  always @(posedge clk) begin
    #1;
    if (frame_seq != seen_seq) begin
      seen_seq   = frame_seq;
      exp_addr   = mem_base;
      addr_errs  = 0;
      n_acks     = 0;
      req_cycles = 0;
    end
    if (!resp_en) begin
      mem_ack   = late_ack;
      mem_rdata = 8'hEE;
      wcnt      = 0;
    end else if (mem_req && !mem_ack) begin
      if (wcnt >= mem_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = 8'(mem_addr - mem_base) + 8'h10;
        if (mem_addr != exp_addr) addr_errs++;
        exp_addr  = exp_addr + 1'b1;
        n_acks++;
        wcnt      = 0;
      end else begin
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
    if (mem_req) req_cycles++;
  end

  // Frame capture: cap[k] is data_out k cycles after the start edge.
  logic [8:0] cap [0:8191];
  int         done_at;
  int         busy_low;
  logic       busy_at_done;
  logic       und_at_done;
  logic       und_at_start;

  task automatic run_frame(input int w, input int h, input logic [ADDR_W-1:0] b,
                           input int lat, input int restart_at);
    mem_lat  = lat;
    mem_base = b;
    frame_seq++;
    @(negedge clk);
    image_width  = w;
    image_height = h;
    base_addr    = b;
    start        = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    done_at  = -1;
    busy_low = 0;
    for (int k = 0; k < 8192; k++) begin
      cap[k] = data_out;
      if (k == 0) und_at_start = underrun;
      if (done) begin
        done_at      = k;
        busy_at_done = busy;
        und_at_done  = underrun;
        break;
      end
      if (!busy) busy_low++;
      start       = (k == restart_at);
      image_width = (k == restart_at) ? 32'd7 : w;
      @(negedge clk);
    end
    start       = 1'b0;
    image_width = w;
    if (done_at < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nz, nv;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 4x3 frame, zero-wait memory
    run_frame(4, 3, 26'h100, 0, -1);
    chk("a_done_at", done_at, 36);
    chk("a_prefill_zero", cap[17], 0);
    for (int i = 0; i < 12; i++) chk($sformatf("a_pix%0d", i), cap[18+i], 9'h110 + i);
    nz = 0;
    for (int i = 30; i < 36; i++) if (cap[i] != 9'h000) nz++;
    chk("a_flush_nonzero", nz, 0);
    chk("a_busy_low", busy_low, 0);
    chk("a_busy_at_done", busy_at_done, 0);
    chk("a_underrun", und_at_done, 0);
    chk("a_addr_errs", addr_errs, 0);
    chk("a_acks", n_acks, 12);
    @(negedge clk);
    chk("a_done_pulse", done, 0);
    repeat (5) @(negedge clk);

    // 8x2 frame, ack latency 3, base wraps the address space
    run_frame(8, 2, 26'h3FFFFFC, 3, -1);
    chk("b_done_at", done_at, 68);
    for (int i = 0; i < 10; i++) chk($sformatf("b_pix%0d", i), cap[42+i], 9'h110 + i);
    chk("b_pix10", cap[56], 9'h11A);
    nz = 0;
    for (int i = 42; i < 58; i++) if (cap[i][8] == 1'b0) nz++;
    chk("b_zero_slots", nz, 5);
    nv = 0;
    for (int i = 0; i <= done_at; i++) if (cap[i][8]) nv++;
    chk("b_valid_words", nv, 11);
    chk("b_underrun", und_at_done, 1);
    chk("b_addr_errs", addr_errs, 0);
    repeat (8) @(negedge clk);

    // start pulsed mid-STREAM with another width is ignored
    run_frame(4, 3, 26'h200, 0, 20);
    chk("c_done_at", done_at, 36);
    chk("c_busy_low", busy_low, 0);
    chk("c_first", cap[18], 9'h110);
    chk("c_last", cap[29], 9'h11B);
    chk("c_flush0", cap[30], 9'h000);
    repeat (5) @(negedge clk);

    // 1024x4, one ack per 4 cycles: sustained underrun
    run_frame(1024, 4, 26'h1000, 2, -1);
    chk("d_done_at", done_at, 5156);
    chk("d_underrun", und_at_done, 1);
    chk("d_addr_errs", addr_errs, 0);
    chk("d_many_acks", (n_acks > 1000), 1);
    repeat (5) @(negedge clk);
    chk("d_underrun_sticky", underrun, 1);

    // Zero width: no memory traffic, immediate done, underrun cleared
    run_frame(0, 5, 26'h0, 0, -1);
    chk("e_done_at", done_at, 1);
    chk("e_underrun_clr", und_at_start, 0);
    repeat (5) @(negedge clk);
    chk("e_no_req", req_cycles, 0);
    nz = 0;
    for (int i = 0; i <= done_at; i++) if (cap[i] != 9'h000) nz++;
    chk("e_data_zero", nz, 0);

    // Reset mid-frame with a request outstanding, then a late ack
    mem_lat  = 3;
    mem_base = 26'h500;
    frame_seq++;
    @(negedge clk);
    image_width  = 8;
    image_height = 2;
    base_addr    = 26'h500;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("f_req_before_rst", mem_req, 1);
    resp_en = 1'b0;
    rst     = 1'b0;
    #1;
    chk("f_rst_req", mem_req, 0);
    chk("f_rst_addr", mem_addr, 0);
    chk("f_rst_busy", busy, 0);
    chk("f_rst_data", data_out, 0);
    @(negedge clk);
    rst      = 1'b1;
    late_ack = 1'b1;
    @(negedge clk);
    late_ack = 1'b0;
    @(negedge clk);
    chk("f_late_req", mem_req, 0);
    chk("f_late_busy", busy, 0);
    chk("f_late_done", done, 0);
    resp_en = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(4, 3, 26'h500, 0, -1);
    chk("f_done_at", done_at, 36);
    chk("f_first", cap[18], 9'h110);
    chk("f_last", cap[29], 9'h11B);
    chk("f_addr_errs", addr_errs, 0);
    chk("f_acks", n_acks, 12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
